mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the instruction-fetch requester and the data (load/store) requester.
- Sequences each transaction as a registered request/acknowledge exchange.
- Handles byte lanes for LB/LBU/SB, using the decoder's byte_op and unsigned_op control signals.
- Enforces bounded fetch starvation and flags misaligned word accesses.
- Sits between the fetch/memory stages and the memory model.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while fetch is pending before fetch is forced; 0 = strict data priority.
BIG_ENDIAN, 1, 1: addr[1:0]=0 selects bits [31:24]; 0: selects bits [7:0].

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
w_fetch_req  in  1  fetch request (level); held until w_fetch_done
w_fetch_addr_32  in  32  fetch byte address
w_fetch_done  out  1  one-cycle completion pulse
w_fetch_data_32  out  32  instruction word; valid with w_fetch_done
w_fetch_err  out  1  misaligned fetch; valid with w_fetch_done
w_data_req  in  1  data request (level); held until w_data_done
w_data_addr_32  in  32  data byte address
w_data_write_op  in  1  1 = store
w_data_byte_op  in  1  1 = byte access
w_data_unsigned_op  in  1  1 = zero-extend byte load
w_data_wdata_32  in  32  store data; byte stores use bits [7:0]
w_data_done  out  1  one-cycle completion pulse
w_data_rdata_32  out  32  load result, extended; valid with w_data_done
w_data_err  out  1  misaligned word access; valid with w_data_done
w_mem_req  out  1  memory request; held until w_mem_ack
w_mem_addr_32  out  32  word address; bits [1:0] always 0
w_mem_write  out  1  1 = write
w_mem_be_4  out  4  byte enables; bit 3 = bits [31:24]
w_mem_wdata_32  out  32  write data
w_mem_ack  in  1  memory done; read data valid this cycle
w_mem_rdata_32  in  32  read word
w_busy  out  1  state is not IDLE

Behaviour:
- All outputs are registered.
- Reset (asynchronous): every output is 0, state is IDLE, starvation counter is 0.
- FSM states: IDLE, MEM_FETCH, MEM_DATA, ERR_RESP.

Arbitration in IDLE:
- A requester whose done pulse is high this cycle is ignored.
- If only one requester is eligible, it is granted.
- If both are eligible: data wins, unless STARVE_LIMIT>0 and starve_cnt==STARVE_LIMIT, in which case fetch wins.
- starve_cnt increments on each data grant made while w_fetch_req is high. It saturates at STARVE_LIMIT. It clears on any fetch grant.

Granting:
- A granted word access with addr[1:0]!=0 goes to ERR_RESP. No memory request is issued. The next cycle gives done=1, err=1, data 0, and the FSM returns to IDLE.
- Otherwise the FSM goes to MEM_FETCH or MEM_DATA. On the next edge it sets w_mem_req=1 and drives addr={addr[31:2],2'b00}.
- w_mem_be_4:
  - 4'b1111 for word accesses.
  - For byte accesses, one-hot on addr[1:0], mapped per BIG_ENDIAN.
- Byte stores replicate wdata[7:0] into all four lanes.
- Fetch accesses are always word reads.

In MEM_*:
- The request fields stay stable while w_mem_ack=0. There is no timeout.
- On the cycle w_mem_ack=1 is sampled, the next edge:
  - clears w_mem_req,
  - pulses the matching done for one cycle,
  - latches the result,
  - returns the FSM to IDLE.
- Earliest next grant is the cycle after done. The minimum fetch turnaround is 3 cycles: grant, req/ack, done.

Load result:
- Word: rdata is the memory word.
- Byte: rdata is the selected lane, sign-extended, or zero-extended if unsigned_op=1.
- Store completion: rdata is 0.

Output and boundary rules:
- Done and err are low in all other cycles. Data outputs hold their last value.
- w_mem_ack while in IDLE or ERR_RESP is ignored.
- A requester dropping req before done is a protocol violation. The transaction still completes.
- Reset mid-transaction drops w_mem_req immediately and discards the transaction. No done pulse is issued.
- Simultaneous assertion of both requests in the same cycle is resolved by the priority rule above.

Test Plan:
- Fetch only, addr 0x00000040, ack on 2nd req cycle, rdata 0x8C220004 -> mem_addr 0x40, be 1111, fetch_done 1 cycle with data 0x8C220004.
- Both requests held continuously, STARVE_LIMIT=4, ack same cycle -> grant order D,D,D,D,F,D,D,D,D,F; no overlap on w_mem_req.
- LB addr 0x101, word 0x11F2_3344, BIG_ENDIAN=1 -> be 0100, rdata 0xFFFFFFF2; the same access with unsigned_op=1 -> 0x000000F2.
- SB addr 0x203, wdata 0x000000AB -> mem_addr 0x200, be 0001, wdata 0xABABABAB, write=1; data_done with rdata 0.
- LW addr 0x006 -> no w_mem_req; data_done=1, data_err=1, rdata 0 two cycles after the request.
- reset_n low while w_mem_req=1 and ack pending -> w_mem_req=0 immediately; done stays 0; a later stray ack is ignored; a new fetch after reset completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported unified memory between the instruction
//             fetch requester and the load/store requester. Each granted
//             access becomes a registered req/ack exchange. Byte lanes are
//             handled for LB/LBU/SB. Fetch starvation is bounded, and word
//             accesses that are not 4-byte aligned are answered with an error.
//  Ports    : clock, reset_n         - clock, async active-low reset
//             w_fetch_*              - fetch requester (level req, done pulse)
//             w_data_*               - load/store requester (level req, done pulse)
//             w_mem_*                - memory side (req held until ack)
//             w_busy                 - arbiter is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter bit BIG_ENDIAN   = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        w_fetch_req,
    input  logic [31:0] w_fetch_addr_32,
    output logic        w_fetch_done,
    output logic [31:0] w_fetch_data_32,
    output logic        w_fetch_err,
    input  logic        w_data_req,
    input  logic [31:0] w_data_addr_32,
    input  logic        w_data_write_op,
    input  logic        w_data_byte_op,
    input  logic        w_data_unsigned_op,
    input  logic [31:0] w_data_wdata_32,
    output logic        w_data_done,
    output logic [31:0] w_data_rdata_32,
    output logic        w_data_err,
    output logic        w_mem_req,
    output logic [31:0] w_mem_addr_32,
    output logic        w_mem_write,
    output logic [3:0]  w_mem_be_4,
    output logic [31:0] w_mem_wdata_32,
    input  logic        w_mem_ack,
    input  logic [31:0] w_mem_rdata_32,
    output logic        w_busy
);
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEM_FETCH = 2'd1,
        MEM_DATA  = 2'd2,
        ERR_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             err_fetch_q, err_fetch_d;   // ERR_RESP answers fetch (1) or data (0)
    logic             byte_q, byte_d;
    logic             unsigned_q, unsigned_d;
    logic [1:0]       lane_q, lane_d;             // physical lane, 3 = bits [31:24]

    logic             fetch_done_q, fetch_done_d;
    logic [31:0]      fetch_data_q, fetch_data_d;
    logic             fetch_err_q, fetch_err_d;
    logic             data_done_q, data_done_d;
    logic [31:0]      data_rdata_q, data_rdata_d;
    logic             data_err_q, data_err_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             mem_write_q, mem_write_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             busy_q, busy_d;

    logic             grant_fetch;
    logic             grant_data;
    logic [1:0]       data_lane;
    logic [7:0]       rd_byte;

    // Byte offset within the word -> physical byte lane.
    assign data_lane = BIG_ENDIAN ? (2'd3 - w_data_addr_32[1:0]) : w_data_addr_32[1:0];

    // No grant at all while a done pulse is out: the finishing requester still
    // holds its request this cycle, and the next grant comes one cycle later.
    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (state_q == IDLE && !fetch_done_q && !data_done_q) begin
            if (w_fetch_req &&
                (!w_data_req || (STARVE_LIMIT > 0 && starve_q == STARVE_MAX))) begin
                grant_fetch = 1'b1;
            end else if (w_data_req) begin
                grant_data = 1'b1;
            end
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (lane_q)
            2'd0:    rd_byte = w_mem_rdata_32[7:0];
            2'd1:    rd_byte = w_mem_rdata_32[15:8];
            2'd2:    rd_byte = w_mem_rdata_32[23:16];
            default: rd_byte = w_mem_rdata_32[31:24];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        err_fetch_d  = err_fetch_q;
        byte_d       = byte_q;
        unsigned_d   = unsigned_q;
        lane_d       = lane_q;
        fetch_done_d = 1'b0;
        fetch_err_d  = 1'b0;
        fetch_data_d = fetch_data_q;
        data_done_d  = 1'b0;
        data_err_d   = 1'b0;
        data_rdata_d = data_rdata_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_write_d  = mem_write_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (grant_fetch) begin
                    starve_d = '0;
                    if (w_fetch_addr_32[1:0] != 2'b00) begin
                        state_d     = ERR_RESP;
                        err_fetch_d = 1'b1;
                    end else begin
                        state_d     = MEM_FETCH;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {w_fetch_addr_32[31:2], 2'b00};
                        mem_write_d = 1'b0;
                        mem_be_d    = 4'b1111;
                    end
                end else if (grant_data) begin
                    // Counts data wins over a waiting fetch; saturates at the limit.
                    if (w_fetch_req && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                    if (!w_data_byte_op && w_data_addr_32[1:0] != 2'b00) begin
                        state_d     = ERR_RESP;
                        err_fetch_d = 1'b0;
                    end else begin
                        state_d     = MEM_DATA;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {w_data_addr_32[31:2], 2'b00};
                        mem_write_d = w_data_write_op;
                        byte_d      = w_data_byte_op;
                        unsigned_d  = w_data_unsigned_op;
                        lane_d      = data_lane;
                        if (w_data_byte_op) begin
                            mem_be_d    = 4'b0001 << data_lane;
                            mem_wdata_d = {4{w_data_wdata_32[7:0]}};
                        end else begin
                            mem_be_d    = 4'b1111;
                            mem_wdata_d = w_data_wdata_32;
                        end
                    end
                end
            end
            MEM_FETCH: begin
                if (w_mem_ack) begin
                    mem_req_d    = 1'b0;
                    fetch_done_d = 1'b1;
                    fetch_data_d = w_mem_rdata_32;
                    state_d      = IDLE;
                end
            end
            MEM_DATA: begin
                if (w_mem_ack) begin
                    mem_req_d   = 1'b0;
                    data_done_d = 1'b1;
                    state_d     = IDLE;
                    if (mem_write_q) begin
                        data_rdata_d = 32'h0;
                    end else if (byte_q) begin
                        data_rdata_d = unsigned_q ? {24'h0, rd_byte}
                                                  : {{24{rd_byte[7]}}, rd_byte};
                    end else begin
                        data_rdata_d = w_mem_rdata_32;
                    end
                end
            end
            ERR_RESP: begin
                state_d = IDLE;
                if (err_fetch_q) begin
                    fetch_done_d = 1'b1;
                    fetch_err_d  = 1'b1;
                    fetch_data_d = 32'h0;
                end else begin
                    data_done_d  = 1'b1;
                    data_err_d   = 1'b1;
                    data_rdata_d = 32'h0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            err_fetch_q  <= 1'b0;
            byte_q       <= 1'b0;
            unsigned_q   <= 1'b0;
            lane_q       <= 2'd0;
            fetch_done_q <= 1'b0;
            fetch_data_q <= 32'h0;
            fetch_err_q  <= 1'b0;
            data_done_q  <= 1'b0;
            data_rdata_q <= 32'h0;
            data_err_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_write_q  <= 1'b0;
            mem_be_q     <= 4'h0;
            mem_wdata_q  <= 32'h0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            err_fetch_q  <= err_fetch_d;
            byte_q       <= byte_d;
            unsigned_q   <= unsigned_d;
            lane_q       <= lane_d;
            fetch_done_q <= fetch_done_d;
            fetch_data_q <= fetch_data_d;
            fetch_err_q  <= fetch_err_d;
            data_done_q  <= data_done_d;
            data_rdata_q <= data_rdata_d;
            data_err_q   <= data_err_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_write_q  <= mem_write_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign w_fetch_done    = fetch_done_q;
    assign w_fetch_data_32 = fetch_data_q;
    assign w_fetch_err     = fetch_err_q;
    assign w_data_done     = data_done_q;
    assign w_data_rdata_32 = data_rdata_q;
    assign w_data_err      = data_err_q;
    assign w_mem_req       = mem_req_q;
    assign w_mem_addr_32   = mem_addr_q;
    assign w_mem_write     = mem_write_q;
    assign w_mem_be_4      = mem_be_q;
    assign w_mem_wdata_32  = mem_wdata_q;
    assign w_busy          = busy_q;

endmodule
`default_nettype wire
